rgb_led: RTL and testbench

Color-wheel sequencer for the board's RGB LED. It holds a rotating one-hot phase in an N-bit shift register, advances the phase on a programmable prescaler tick, and decodes the top six phase bits into active-high red/green/blue drive. The top level inverts these outputs for the active-low LED pins. The block is instantiated once, directly under the board top.

---
 rtl/rgb_led_if.sv | 26 ++
 rtl/rgb_led.sv | 83 ++++++++
 tb/tb_rgb_led.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rgb_led_if.sv
// Signal bundle for the rgb_led colour-wheel sequencer: control and load inputs,
// shift register contents and active-high colour drive.
interface rgb_led_if #(
    parameter int N = 6
);
    logic         load;
    logic         sin;
    logic [N-1:0] d;
    logic [N-1:0] q;
    logic         south;
    logic         red;
    logic         green;
    logic         blue;

    // Plain level signals with no handshake: load/sin/d are sampled on every
    // rising clk edge; q/south/colours are valid continuously.
    modport master (
        output load, sin, d,
        input  q, south, red, green, blue
    );

    modport slave (
        input  load, sin, d,
        output q, south, red, green, blue
    );
endinterface

// File: rtl/rgb_led.sv
// Colour-wheel sequencer: one-hot phase rotated on a prescaler tick and decoded to RGB.
// Optional PWM dimming is built when the macro RGB_LED_PWM_EN is defined.
module rgb_led #(
    parameter int             N           = 6,
    parameter int             STEP_CYCLES = 2_000_000,
    parameter logic [N-1:0]   RESET_PHASE = N'(6'b100000),
    parameter logic [7:0]     DUTY        = 8'd255
) (
    input  logic      clk,
    input  logic      reset,
    rgb_led_if.slave  bus
);

    localparam int           CW      = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STEP_CYCLES - 1);

    logic [N-1:0]  q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;
    logic [5:0]    o;
    logic          red_raw, green_raw, blue_raw;
    logic          pwm_on;

    assign tick = (cnt_q == CNT_MAX);

    // Load restarts the prescaler, so a tick coinciding with a load is dropped.
    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q + CW'(1);
        if (tick) begin
            cnt_d = '0;
        end
        if (bus.load) begin
            q_d   = bus.d;
            cnt_d = '0;
        end else if (tick) begin
            q_d = {q_q[0] | bus.sin, q_q[N-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q   <= RESET_PHASE;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    // Only the top six phase bits select colours; any lower bits just circulate.
    assign o = q_q[N-1:N-6];

    always_comb begin
        red_raw   = o[5] | o[4] | o[0];
        green_raw = o[4] | o[3] | o[2];
        blue_raw  = o[2] | o[1] | o[0];
    end

`ifdef RGB_LED_PWM_EN
    logic [7:0] pwm_q, pwm_d;

    assign pwm_d  = pwm_q + 8'd1;
    assign pwm_on = (pwm_q < DUTY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_q <= 8'd0;
        end else begin
            pwm_q <= pwm_d;
        end
    end
`else
    assign pwm_on = 1'b1;
`endif

    assign bus.q     = q_q;
    assign bus.south = q_q[0];
    assign bus.red   = red_raw   & pwm_on;
    assign bus.green = green_raw & pwm_on;
    assign bus.blue  = blue_raw  & pwm_on;

endmodule

// File: tb/tb_rgb_led.sv
// Self-checking bench for rgb_led: directed wheel/load/sin/reset scenarios plus
// randomized load/sin traffic, compared against a phase/colour reference model.
module tb_rgb_led;
  localparam int N    = 6;
  localparam int STEP = 4;
  localparam int DUTY = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rgb_led_if #(.N(N)) bus ();

  rgb_led #(
    .N(N),
    .STEP_CYCLES(STEP),
    .DUTY(8'(DUTY))
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state: phase value, edges since last load/reset, pwm phase
  logic [N-1:0] m_q;
  int           m_since;
  logic [7:0]   m_pwm;
  logic [N+3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // colour contributed by each phase bit, listed from o[5] down to o[0]
  function automatic logic [2:0] color_of(input logic [N-1:0] v, input logic [7:0] pwm);
    logic [2:0] contrib [6];
    logic [2:0] c;
    contrib = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    c = 3'b000;
    for (int i = 0; i < 6; i++)
      if (v[N-1-i]) c = c | contrib[i];
`ifdef RGB_LED_PWM_EN
    if (!(int'(pwm) < DUTY)) c = 3'b000;
`else
    if (pwm === 8'hxx) c = 3'b000;
`endif
    return c;
  endfunction

  function automatic logic [N+3:0] observed();
    return {bus.q, bus.red, bus.green, bus.blue, bus.south};
  endfunction

  function automatic logic [N+3:0] expected();
    return {m_q, color_of(m_q, m_pwm), m_q[0]};
  endfunction

  task automatic model_reset();
    m_q     = N'(6'b100000);
    m_since = 0;
    m_pwm   = 8'd0;
  endtask

  // one rising edge: advance model with the inputs present at the edge, then compare
  task automatic step();
    @(posedge clk);
    if (bus.load) begin
      m_q     = bus.d;
      m_since = 0;
    end else begin
      m_since++;
      if (m_since % STEP == 0)
        m_q = {m_q[0] | bus.sin, m_q[N-1:1]};
    end
    m_pwm = m_pwm + 8'd1;
    #1;
    exp_q.push_back(expected());
    check("cycle", 32'(observed()), 32'(exp_q.pop_front()));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_rgb(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, bus.red, bus.green, bus.blue}, {29'd0, exp});
  endtask

  task automatic sync_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_q", 32'(bus.q), 32'(6'b100000));
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int red_cnt;
    reset    = 1'b0;
    bus.load = 1'b0;
    bus.sin  = 1'b0;
    bus.d    = '0;
    model_reset();
    #12;
    check("rst_q", 32'(bus.q), 32'(6'b100000));
    check_rgb("rst_rgb", 3'b100);
    check("rst_south", 32'(bus.south), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // first step lands on the STEP-th edge after release
    for (int i = 0; i < STEP - 1; i++) begin
      step();
      check("hold_q", 32'(bus.q), 32'(6'b100000));
    end
    step();
    check("first_step_q", 32'(bus.q), 32'(6'b010000));
    check_rgb("first_step_rgb", 3'b110);

    // remainder of a full wheel: back to red after 24 edges in total
    steps(6 * STEP - STEP);
    check("wheel_wrap_q", 32'(bus.q), 32'(6'b100000));
    check_rgb("wheel_wrap_rgb", 3'b100);

    // load in mid-count
    steps(2);
    bus.load = 1'b1;
    bus.d    = 6'b000010;
    step();
    bus.load = 1'b0;
    check("load_q", 32'(bus.q), 32'(6'b000010));
    check_rgb("load_rgb", 3'b001);
    steps(STEP - 1);
    check("load_hold_q", 32'(bus.q), 32'(6'b000010));
    step();
    check("load_next_q", 32'(bus.q), 32'(6'b000001));
    check("south_hi", 32'(bus.south), 32'd1);

    // load coincident with tick: the shift is lost
    steps(STEP - 1);
    bus.load = 1'b1;
    bus.d    = 6'b001000;
    step();
    bus.load = 1'b0;
    check("load_tick_q", 32'(bus.q), 32'(6'b001000));

    // sin injection from the reset phase
    sync_reset();
    bus.sin = 1'b1;
    steps(STEP);
    check("sin1_q", 32'(bus.q), 32'(6'b110000));
    check_rgb("sin1_rgb", 3'b110);
    steps(4 * STEP);
    check("sin5_q", 32'(bus.q), 32'(6'b111111));
    check_rgb("sin5_rgb", 3'b111);
    bus.sin = 1'b0;

    // asynchronous reset between edges
    bus.load = 1'b1;
    bus.d    = 6'b000100;
    step();
    bus.load = 1'b0;
    step();
    check("pre_arst_q", 32'(bus.q), 32'(6'b000100));
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check("arst_q", 32'(bus.q), 32'(6'b100000));
    check_rgb("arst_rgb", 3'b100);
    @(negedge clk);
    reset = 1'b1;

`ifdef RGB_LED_PWM_EN
    // freeze the phase on red and count lit cycles over one pwm period
    red_cnt  = 0;
    bus.load = 1'b1;
    bus.d    = 6'b100000;
    for (int i = 0; i < 256; i++) begin
      step();
      if (bus.red) red_cnt++;
    end
    bus.load = 1'b0;
    check("pwm_duty", 32'(red_cnt), 32'(DUTY));
`else
    red_cnt = 0;
`endif

    // randomized load/sin traffic
    for (int i = 0; i < 400; i++) begin
      bus.load = ($urandom_range(0, 7) == 0);
      bus.sin  = ($urandom_range(0, 3) == 0);
      bus.d    = N'($urandom_range(0, (1 << N) - 1));
      step();
    end
    bus.load = 1'b0;
    bus.sin  = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule
